// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe stage: the occupancy state machine encoding
// and the occupancy constants that the state maps onto.
package pipe_pkg;

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_of(input state_e s);
    case (s)
      ONE:     occ_of = OCC_ONE;
      TWO:     occ_of = OCC_TWO;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Increment on inc unless already saturated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with optional skid slot. With SKID=1 in_ready is
// a flop (breaks the out_ready -> in_ready timing path); with SKID=0 the stage
// holds one payload and in_ready passes out_ready through combinationally.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_fire, out_fire;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state);

  // State and payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  // Next state and slot updates; flush overrides everything, including a
  // same-cycle accept, while a same-cycle delivery has already happened.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            // Only reachable with a skid slot; without one in_ready implies out_ready here.
            if (SKID != 0) begin
              skid_nxt  = in_data;
              state_nxt = TWO;
            end
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_nxt  = skid_q;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  if (SKID != 0) begin : g_skid
    logic rdy_q;
    // Registered ready: precomputed from next state, low while in reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) rdy_q <= 1'b0;
      else        rdy_q <= (state_nxt != TWO);
    end
    assign in_ready = rdy_q;
  end else begin : g_noskid
    assign in_ready = (state == EMPTY) | out_ready;
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter SKID, default 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
REQ-003 Parameter CNT_W, default 16: stall counter width, legal range 1..32.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low; asserted while 0.
REQ-006 in_valid  input  1: upstream payload valid.
REQ-007 in_ready  output  1: stage accepts a payload this cycle.
REQ-008 in_data  input  DATA_W: upstream payload.
REQ-009 flush  input  1: synchronous kill of all held payloads.
REQ-010 out_valid  output  1: out_data holds a valid payload.
REQ-011 out_ready  input  1: downstream accepts a payload.
REQ-012 out_data  output  DATA_W: payload from the main slot.
REQ-013 occupancy  output  2: number of held payloads, 0..2.
REQ-014 stall_cnt  output  CNT_W: saturating count of back-pressured cycles.

Function
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 States: EMPTY (occupancy 0), ONE (main slot full, occupancy 1), TWO (main and skid slots full, occupancy 2); TWO exists only when SKID=1.
REQ-017 out_valid SHALL be 1 exactly in ONE or TWO; out_data SHALL always equal the main-slot register.
REQ-018 SKID=1: in_ready SHALL equal (state != TWO), driven directly from a register with no combinational path from out_ready.
REQ-019 SKID=0: in_ready SHALL equal (state == EMPTY) | out_ready.
REQ-020 EMPTY: on in_fire, load main from in_data and go to ONE; otherwise stay in EMPTY.
REQ-021 ONE with in_fire and out_fire: load main from in_data and stay in ONE.
REQ-022 ONE with in_fire only: SKID=1 loads skid from in_data and goes to TWO (SKID=0 cannot reach this case).
REQ-023 ONE with out_fire only: go to EMPTY.
REQ-024 ONE with neither: hold state and main.
REQ-025 TWO with out_fire: copy skid to main and go to ONE; otherwise hold.
REQ-026 Ordering SHALL be strict FIFO; no payload is duplicated or dropped except by flush.
REQ-027 Zero-bubble throughput: with in_valid=out_ready=1 held continuously, exactly one payload SHALL transfer per cycle from the second cycle on.
REQ-028 Input-to-output latency SHALL be 1 cycle when the stage is empty.
REQ-029 flush=1 SHALL take priority: next state EMPTY, main and skid cleared to 0, and a same-cycle in_fire discarded; a same-cycle out_fire still counts as a delivered transfer.
REQ-030 stall_cnt SHALL increment by 1 each cycle where out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-031 The stage SHALL accept in_data values without any interpretation; the payload is opaque at full DATA_W width.

Reset
REQ-032 While reset=0, asynchronously force: state EMPTY, main=0, skid=0, stall_cnt=0, out_valid=0, occupancy=0.
REQ-033 While reset=0, in_ready SHALL be 0 when SKID=1 and SHALL follow REQ-019 when SKID=0.
REQ-034 in_ready SHALL become 1 on the first rising edge after reset is released.
REQ-035 Reset asserted in the middle of any transfer SHALL discard all payloads without producing a partial output.

Structure
REQ-036 A shared package pipe_pkg SHALL hold the state enumeration (EMPTY/ONE/TWO) and the occupancy encoding constants.
REQ-037 A single sub-module, pipe_sat_counter (parameter CNT_W, inputs inc/clk/reset), SHALL implement stall_cnt.
REQ-038 No latches; every register resets asynchronously.

Verification
REQ-039 SKID=1: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data shows 0x11, 0x22, 0x33 on cycles 1, 2, 3 with out_valid=1.
REQ-040 SKID=1: out_ready=0, push 0xA1, then 0xA2 -> occupancy 2, in_ready=0, 0xA3 held upstream; release out_ready -> outputs 0xA1, 0xA2, 0xA3 in order.
REQ-041 In state TWO, assert flush together with in_valid carrying 0xFF -> next cycle occupancy=0, out_valid=0, out_data=0; 0xFF never appears.
REQ-042 CNT_W=3: hold out_valid=1 with out_ready=0 for 10 cycles -> stall_cnt reaches 7 and holds at 7.
REQ-043 Assert reset=0 asynchronously mid-stream while occupancy=2 -> outputs clear immediately, before the next clock edge; after release, in_ready=1 on the first edge.
REQ-044 SKID=0: in_valid=1 with out_ready toggling 1,0,1 -> in_ready tracks out_ready while full, and no payload is lost.
